// File: rtl/regfile_pkg.sv
// Shared constants and FSM state encoding for the 8x16 register file.
// REGFILE_BYPASS_EN (in regfile_8x16) selects write-to-read forwarding.
package regfile_pkg;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = $clog2(NUM_REGS);

    // One-bit state register kept as plain logic constants for older tool flows
    typedef logic [0:0] state_t;
    localparam state_t IDLE  = 1'b0;
    localparam state_t CLEAR = 1'b1;

endpackage

// File: rtl/reg16_ce.sv
// Single storage register with clock enable and asynchronous active-low clear.
module reg16_ce #(
    parameter int DATA_W = regfile_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile_8x16.sv
// Register file with two registered read ports, one handshaked write port and a
// sequential clear engine. Define REGFILE_BYPASS_EN to forward same-edge writes to reads.
module regfile_8x16 #(
    parameter int DATA_W    = regfile_pkg::DATA_W,
    parameter int NUM_REGS  = regfile_pkg::NUM_REGS,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              clr_req,
    output logic              busy
);

    import regfile_pkg::state_t;
    import regfile_pkg::IDLE;
    import regfile_pkg::CLEAR;

    state_t              state;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] reg_en;
    logic [DATA_W-1:0]   load_val;
    logic                clearing;
    logic                wr_fire;
    logic                last_clr;
    logic                fwd_a;
    logic                fwd_b;

    assign clearing = (state == CLEAR);
    assign wr_ready = (state == IDLE);
    assign busy     = clearing;
    assign wr_fire  = wr_valid && wr_ready;
    assign last_clr = (clr_cnt == ADDR_W'(NUM_REGS - 1));
    assign load_val = clearing ? '0 : wr_data;

    // clr_req is only looked at in IDLE, so a re-pulse mid-clear cannot restart it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            clr_cnt <= '0;
        end else if (state == IDLE) begin
            if (clr_req) begin
                state   <= CLEAR;
                clr_cnt <= '0;
            end
        end else begin
            if (last_clr) begin
                state   <= IDLE;
                clr_cnt <= '0;
            end else begin
                clr_cnt <= clr_cnt + ADDR_W'(1);
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        assign reg_en[i] = (clearing && (clr_cnt == ADDR_W'(i)))
                         || (wr_fire && (wr_addr == ADDR_W'(i)));

        reg16_ce #(
            .DATA_W (DATA_W)
        ) u_reg (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (reg_en[i]),
            .d     (load_val),
            .q     (regs[i])
        );
    end

    // Forwarding keys off wr_fire, which is never set while clearing
`ifdef REGFILE_BYPASS_EN
    assign fwd_a = wr_fire && (wr_addr == rd_addr_a);
    assign fwd_b = wr_fire && (wr_addr == rd_addr_b);
`else
    assign fwd_a = 1'b0;
    assign fwd_b = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else begin
            rd_data_a <= fwd_a ? wr_data : regs[rd_addr_a];
            rd_data_b <= fwd_b ? wr_data : regs[rd_addr_b];
        end
    end

endmodule

// File: doc/regfile_8x16.md
REGFILE_8X16 -- requirements
Module: regfile_8x16

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 8, register count; ADDR_W = log2(NUM_REGS) = 3.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 wr_valid  input  1  write request.
REQ-007 wr_ready  output  1  write can be accepted this cycle.
REQ-008 wr_addr  input  ADDR_W  write register index.
REQ-009 wr_data  input  DATA_W  write data.
REQ-010 rd_addr_a / rd_addr_b  input  ADDR_W  read port A/B index.
REQ-011 rd_data_a / rd_data_b  output  DATA_W  registered read data A/B.
REQ-012 clr_req  input  1  single-cycle pulse requesting clear of all registers.
REQ-013 busy  output  1  clear sequence in progress.

Function
REQ-014 SHALL hold NUM_REGS registers of DATA_W bits; none hardwired.
REQ-015 Write handshake: write accepted at rising edge when wr_valid=1 and wr_ready=1; the register holds wr_data from that edge on.
REQ-016 wr_ready SHALL be 1 exactly when FSM is IDLE; combinational decode of state only, no dependence on wr_valid.
REQ-017 wr_valid while wr_ready=0: no write; the requester holds wr_addr/wr_data until accepted.
REQ-018 Read latency 1 cycle: each edge, rd_data_x <= reg[rd_addr_x]; both ports independent, same address allowed.
REQ-019 FSM states IDLE, CLEAR; IDLE -> CLEAR on clr_req=1; CLEAR -> IDLE after the register with index NUM_REGS-1 is zeroed.
REQ-020 In CLEAR, a 3-bit counter starting at 0 SHALL zero reg[counter] each cycle and increment; the sequence takes exactly NUM_REGS cycles.
REQ-021 busy SHALL be 1 exactly in CLEAR.
REQ-022 clr_req in CLEAR SHALL be ignored, with no restart and no extension.
REQ-023 clr_req and accepted write in the same IDLE cycle: the write completes, CLEAR starts next cycle and later zeroes that register.
REQ-024 Reads during CLEAR SHALL return current contents; registers already zeroed read 0.
REQ-025 Counter wrap from NUM_REGS-1 to 0 SHALL coincide with return to IDLE.

Reset
REQ-026 rst_n=0 SHALL asynchronously set all registers to 0, rd_data_a=rd_data_b=0, state IDLE (wr_ready=1, busy=0), and counter 0.
REQ-027 Reset during CLEAR SHALL abort the sequence; after release the FSM is IDLE and all registers are 0.
REQ-028 No write or clear SHALL be accepted at the first edge while rst_n=0.

Configuration
REQ-029 Macro REGFILE_BYPASS_EN defined: a write accepted at the same edge to the same address as rd_addr_x SHALL load wr_data into rd_data_x.
REQ-030 Macro REGFILE_BYPASS_EN undefined: rd_data_x SHALL load the pre-write value in that case, and the new value one cycle later.
REQ-031 Bypass SHALL never forward during CLEAR; the clear zero is not forwarded under either configuration.

Structure
REQ-032 Package regfile_pkg SHALL hold DATA_W, NUM_REGS, ADDR_W constants and the FSM state type (IDLE, CLEAR).
REQ-033 Sub-module reg16_ce SHALL implement one DATA_W-bit register with clock enable, synchronous load value, and async active-low clear, instantiated NUM_REGS times.
REQ-034 Write-enable decode and clear-counter selection SHALL drive each reg16_ce enable; no other sub-modules.

Verification
REQ-035 Reset then write 0x1234 to R3, then read A=R3 next cycle -> rd_data_a=0x1234 one cycle after the address is applied.
REQ-036 Write 0xBEEF to R5 while rd_addr_b=5 in the same cycle -> rd_data_b=0xBEEF next edge with BYPASS_EN, old value (0) without.
REQ-037 Fill R0..R7 with 0x0001..0x0008, pulse clr_req -> busy=1 for 8 cycles, wr_ready=0 throughout, all reads 0 afterwards.
REQ-038 wr_valid=1 to R2 with 0xAAAA held during CLEAR -> write accepted on first IDLE cycle, R2=0xAAAA afterwards.
REQ-039 Assert rst_n=0 at clear cycle 4 -> immediate busy=0, rd_data=0; after release all registers read 0, wr_ready=1.
REQ-040 clr_req re-pulsed at clear cycle 3 -> busy still drops exactly 8 cycles after the first pulse.
